// File: rtl/perf_pkg.sv
// Shared types and defaults for the performance-event dump controller.
// Build option PERF_CLEAR_ON_DUMP_EN is consumed by perf_dump_ctrl.
package perf_pkg;

    localparam int unsigned PerfNumEvents = 16;
    localparam int unsigned PerfCntWidth  = 32;

    typedef logic [1:0] perf_dump_state_t;

    localparam perf_dump_state_t StIdle = 2'd0;
    localparam perf_dump_state_t StDump = 2'd1;
    localparam perf_dump_state_t StDone = 2'd2;

    typedef logic [$clog2(PerfNumEvents)-1:0] perf_idx_t;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating event counter with synchronous clear and load.
// Priority: clear, then load, then increment.
module perf_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/perf_dump_ctrl.sv
// Perf event counter bank with snapshot dump over a valid/ready stream, cycle counter
// and log window gate. Define PERF_CLEAR_ON_DUMP_EN to restart live counters at each dump.
module perf_dump_ctrl
    import perf_pkg::*;
#(
    parameter int unsigned NUM_EVENTS = PerfNumEvents,
    parameter int unsigned CNT_WIDTH  = PerfCntWidth
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_EVENTS-1:0]         event_i,
    input  logic                          clear_i,
    input  logic [63:0]                   log_start_i,
    input  logic [63:0]                   log_end_i,
    input  logic                          dump_req_i,
    output logic                          dump_busy_o,
    output logic                          dump_valid_o,
    input  logic                          dump_ready_i,
    output logic [$clog2(NUM_EVENTS)-1:0] dump_idx_o,
    output logic [CNT_WIDTH-1:0]          dump_cnt_o,
    output logic [63:0]                   dump_cycle_o,
    output logic                          dump_done_o,
    output logic [63:0]                   cycle_cnt_o,
    output logic                          log_valid_o
);

    localparam int unsigned IdxW = $clog2(NUM_EVENTS);

    perf_dump_state_t     state_q, state_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [63:0]          cycle_q;
    logic [63:0]          snap_cycle_q;
    logic                 log_valid_q;
    logic [CNT_WIDTH-1:0] live_cnt [NUM_EVENTS];
    logic [CNT_WIDTH-1:0] shadow_q [NUM_EVENTS];
    logic                 snap;
    logic                 load_live;

    assign snap = (state_q == StIdle) && dump_req_i;

`ifdef PERF_CLEAR_ON_DUMP_EN
    assign load_live = snap;
`else
    assign load_live = 1'b0;
`endif

    for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_cnt
        perf_sat_counter #(
            .WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .inc_i      (event_i[g]),
            .clr_i      (clear_i),
            .load_i     (load_live),
            .load_val_i ({{(CNT_WIDTH-1){1'b0}}, event_i[g]}),
            .cnt_o      (live_cnt[g])
        );
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                if (dump_req_i) begin
                    state_d = StDump;
                    idx_d   = '0;
                end
            end
            StDump: begin
                if (dump_ready_i) begin
                    if (idx_q == IdxW'(NUM_EVENTS - 1)) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            cycle_q      <= '0;
            snap_cycle_q <= '0;
            log_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cycle_q     <= cycle_q + 64'd1;
            // Window is half-open, so start >= end never opens the gate.
            log_valid_q <= (log_start_i <= cycle_q) && (cycle_q < log_end_i);
            if (snap) begin
                snap_cycle_q <= cycle_q;
            end
        end
    end

    // Shadow captures the registered counts, so a same-cycle event or clear is excluded.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (rst) begin
                shadow_q[i] <= '0;
            end else if (snap) begin
                shadow_q[i] <= live_cnt[i];
            end
        end
    end

    assign dump_valid_o = (state_q == StDump);
    assign dump_busy_o  = (state_q == StDump);
    assign dump_done_o  = (state_q == StDone);
    assign dump_idx_o   = idx_q;
    assign dump_cnt_o   = shadow_q[idx_q];
    assign dump_cycle_o = snap_cycle_q;
    assign cycle_cnt_o  = cycle_q;
    assign log_valid_o  = log_valid_q;

endmodule

// File: tb/tb_perf_dump_ctrl.sv
// Directed bench for perf_dump_ctrl: main 16x32 instance plus a 4x4 instance for saturation.
// Expected values follow PERF_CLEAR_ON_DUMP_EN when the bench is built with it defined.
module tb_perf_dump_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] event_v;
    logic        clear;
    logic [63:0] log_start, log_end;
    logic        dump_req, dump_ready;
    logic        busy, valid, done, log_valid;
    logic [3:0]  idx;
    logic [31:0] cnt;
    logic [63:0] dcycle, cycle_cnt;

    logic [3:0]  s_event;
    logic        s_req;
    logic        s_ready = 1'b1;
    logic        s_clear = 1'b0;
    logic [63:0] s_log_zero = 64'd0;
    logic        s_busy, s_valid, s_done, s_log_valid;
    logic [1:0]  s_idx;
    logic [3:0]  s_cnt;
    logic [63:0] s_dcycle, s_cycle_cnt;

    logic [63:0] model_cyc;
    logic [31:0] exp_cnt [16];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) model_cyc <= rst ? 64'd0 : model_cyc + 64'd1;

    perf_dump_ctrl u_dut (
        .clk          (clk),
        .rst          (rst),
        .event_i      (event_v),
        .clear_i      (clear),
        .log_start_i  (log_start),
        .log_end_i    (log_end),
        .dump_req_i   (dump_req),
        .dump_busy_o  (busy),
        .dump_valid_o (valid),
        .dump_ready_i (dump_ready),
        .dump_idx_o   (idx),
        .dump_cnt_o   (cnt),
        .dump_cycle_o (dcycle),
        .dump_done_o  (done),
        .cycle_cnt_o  (cycle_cnt),
        .log_valid_o  (log_valid)
    );

    perf_dump_ctrl #(
        .NUM_EVENTS (4),
        .CNT_WIDTH  (4)
    ) u_dut_sat (
        .clk          (clk),
        .rst          (rst),
        .event_i      (s_event),
        .clear_i      (s_clear),
        .log_start_i  (s_log_zero),
        .log_end_i    (s_log_zero),
        .dump_req_i   (s_req),
        .dump_busy_o  (s_busy),
        .dump_valid_o (s_valid),
        .dump_ready_i (s_ready),
        .dump_idx_o   (s_idx),
        .dump_cnt_o   (s_cnt),
        .dump_cycle_o (s_dcycle),
        .dump_done_o  (s_done),
        .cycle_cnt_o  (s_cycle_cnt),
        .log_valid_o  (s_log_valid)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 16; i++) exp_cnt[i] = 32'd0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // Issues a request in the current cycle and drains the stream, checking order and values.
    task automatic run_dump(input bit toggle, input string tag);
        logic [63:0] exp_cyc;
        logic [3:0]  h_idx;
        logic [31:0] h_cnt;
        int          seen;
        bit          got_done;
        bit          held;
        seen     = 0;
        got_done = 1'b0;
        held     = 1'b0;
        h_idx    = '0;
        h_cnt    = '0;
        dump_req = 1'b1;
        exp_cyc  = model_cyc;
        step();
        dump_req = 1'b0;
        event_v  = '0;
        clear    = 1'b0;
        for (int k = 1; k < 80; k++) begin
            if (done) begin
                got_done = 1'b1;
                check_val({tag, "_entries"}, 64'(seen), 64'd16);
                check_val({tag, "_busy_in_done"}, {63'd0, busy}, 64'd0);
                if (!toggle) check_val({tag, "_done_latency"}, 64'(k), 64'd17);
            end else if (valid) begin
                check_val({tag, "_busy"}, {63'd0, busy}, 64'd1);
                if (held) begin
                    check_val({tag, "_hold_idx"}, {60'd0, idx}, {60'd0, h_idx});
                    check_val({tag, "_hold_cnt"}, {32'd0, cnt}, {32'd0, h_cnt});
                end
                dump_ready = toggle ? ((k % 2) == 1) : 1'b1;
                if (dump_ready) begin
                    if (seen >= 16) begin
                        check_val({tag, "_extra_entry"}, 64'(seen), 64'd15);
                    end else begin
                        check_val({tag, "_idx"}, {60'd0, idx}, 64'(seen));
                        check_val({tag, "_cnt"}, {32'd0, cnt}, {32'd0, exp_cnt[seen]});
                        check_val({tag, "_cycle"}, dcycle, exp_cyc);
                    end
                    seen++;
                    held = 1'b0;
                end else begin
                    held  = 1'b1;
                    h_idx = idx;
                    h_cnt = cnt;
                end
            end else begin
                check_val({tag, "_valid"}, {63'd0, valid}, 64'd1);
            end
            step();
            if (got_done) break;
        end
        dump_ready = 1'b0;
        check_val({tag, "_done_seen"}, {63'd0, got_done}, 64'd1);
        check_val({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
        check_val({tag, "_idle_valid"}, {63'd0, valid}, 64'd0);
    endtask

    initial begin
        int n_high;
        rst        = 1'b1;
        event_v    = '0;
        clear      = 1'b0;
        log_start  = 64'd0;
        log_end    = 64'd0;
        dump_req   = 1'b0;
        dump_ready = 1'b0;
        s_event    = '0;
        s_req      = 1'b0;
        repeat (3) step();

        check_val("rst_valid", {63'd0, valid}, 64'd0);
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_done", {63'd0, done}, 64'd0);
        check_val("rst_idx", {60'd0, idx}, 64'd0);
        check_val("rst_cnt", {32'd0, cnt}, 64'd0);
        check_val("rst_cycle_cnt", cycle_cnt, 64'd0);
        check_val("rst_dump_cycle", dcycle, 64'd0);
        check_val("rst_log_valid", {63'd0, log_valid}, 64'd0);

        rst = 1'b0;
        repeat (3) step();
        check_val("cycle_run", cycle_cnt, 64'd3);

        // Degenerate window (start >= end) keeps the gate closed throughout.
        log_start = 64'd20;
        log_end   = 64'd3;

        event_v = 16'h0009;
        repeat (5) step();
        event_v = '0;
        clear_exp();
        exp_cnt[0] = 32'd5;
        exp_cnt[3] = 32'd5;
        run_dump(1'b0, "evt03");
        check_val("log_degenerate", {63'd0, log_valid}, 64'd0);

        // Counter k sees 16-k events.
        pulse_clear();
        for (int c = 0; c < 16; c++) begin
            for (int b = 0; b < 16; b++) event_v[b] = (c >= b);
            step();
        end
        event_v = '0;
        clear_exp();
        for (int i = 0; i < 16; i++) exp_cnt[i] = 32'(16 - i);
        run_dump(1'b1, "toggle");

        s_event = 4'b0001;
        repeat (20) step();
        s_event = '0;
        s_req   = 1'b1;
        step();
        s_req   = 1'b0;
        check_val("sat_valid", {63'd0, s_valid}, 64'd1);
        check_val("sat_idx0", {62'd0, s_idx}, 64'd0);
        check_val("sat_cnt0", {60'd0, s_cnt}, 64'd15);
        step();
        check_val("sat_idx1", {62'd0, s_idx}, 64'd1);
        check_val("sat_cnt1", {60'd0, s_cnt}, 64'd0);
        repeat (3) step();
        check_val("sat_done", {63'd0, s_done}, 64'd1);

        pulse_clear();
        event_v = 16'h0002;
        repeat (7) step();
        clear = 1'b1;
        clear_exp();
        exp_cnt[1] = 32'd7;
        run_dump(1'b0, "clr_snap");
        clear_exp();
        run_dump(1'b0, "clr_after");

        pulse_clear();
        event_v = 16'h0004;
        repeat (3) step();
        clear_exp();
        exp_cnt[2] = 32'd3;
        run_dump(1'b0, "delta1");
        event_v = 16'h0004;
        repeat (2) step();
        event_v = '0;
`ifdef PERF_CLEAR_ON_DUMP_EN
        exp_cnt[2] = 32'd3;
`else
        exp_cnt[2] = 32'd6;
`endif
        run_dump(1'b0, "delta2");

        rst       = 1'b1;
        log_start = 64'd10;
        log_end   = 64'd12;
        step();
        rst    = 1'b0;
        n_high = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            check_val("log_window", {63'd0, log_valid}, {63'd0, (i == 11) || (i == 12)});
            if (log_valid) n_high++;
        end
        check_val("log_high_cycles", 64'(n_high), 64'd2);

        dump_req = 1'b1;
        step();
        dump_req   = 1'b0;
        dump_ready = 1'b1;
        repeat (4) step();
        check_val("mid_valid", {63'd0, valid}, 64'd1);
        rst = 1'b1;
        step();
        check_val("mid_rst_valid", {63'd0, valid}, 64'd0);
        check_val("mid_rst_busy", {63'd0, busy}, 64'd0);
        check_val("mid_rst_done", {63'd0, done}, 64'd0);
        check_val("mid_rst_idx", {60'd0, idx}, 64'd0);
        check_val("mid_rst_cnt", {32'd0, cnt}, 64'd0);
        check_val("mid_rst_cycle", cycle_cnt, 64'd0);
        check_val("mid_rst_dcycle", dcycle, 64'd0);
        rst    = 1'b0;
        n_high = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done || valid) n_high++;
        end
        check_val("mid_rst_no_done", 64'(n_high), 64'd0);
        dump_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
